draw_lines: RTL and testbench
=============================

# draw_lines

Line rasteriser with a private 1-bit frame buffer. On a clear request it blanks the buffer and draws a Bresenham line between two endpoint coordinates, one pixel per clock. It also serves raster reads addressed by the display's horizontal and vertical counters. It sits between the geometry/projection logic, which supplies the endpoints, and the VGA timing/pixel path, which consumes `o_pixel_on`.

## Interface
- `H_RES`, default 32: buffer width in pixels (columns 0..H_RES-1).
- `V_RES`, default 32: buffer height in pixels (rows 0..V_RES-1).
- `i_clk`  in  1: single system clock; all logic is on its rising edge.
- `i_reset`  in  1: reset, synchronous and active-high.
- `i_x0`, `i_y0`  in  11 each: start point, unsigned pixel coordinates.
- `i_x1`, `i_y1`  in  11 each: end point, unsigned pixel coordinates.
- `i_clear_buffer`  in  1: request to clear the buffer and redraw; a one-cycle pulse is sufficient.
- `i_hcounter`, `i_vcounter`  in  11 each: raster read address (column, row).
- `o_waiting`  out  1: high when idle and ready for a new request.
- `o_pixel_on`  out  1: registered buffer bit at the read address.

## Operation
- Buffer organisation: V_RES row words, each H_RES bits wide.
- FSM states: RST_CLR, IDLE, CLEAR, SETUP, DRAW.
- Reset:
  - Forces RST_CLR, which zeroes one row per cycle (V_RES cycles) and then goes to IDLE without drawing.
  - `o_waiting`=0 and `o_pixel_on`=0 during reset.
- IDLE:
  - `o_waiting`=1.
  - `i_clear_buffer`=1 latches all four endpoints that same cycle and goes to CLEAR.
  - Endpoint inputs are ignored at all other times.
  - `i_clear_buffer` outside IDLE is ignored; no queuing.
- CLEAR: zeroes rows 0..V_RES-1, one per cycle, then goes to SETUP.
- SETUP (1 cycle):
  - dx=|x1-x0|, dy=|y1-y0|.
  - sx/sy = +1 or -1 per direction.
  - err=dx-dy.
  - Cursor = (x0,y0).
  - Arithmetic is 13-bit signed; no overflow is possible for 11-bit inputs.
- DRAW:
  - Each cycle sets the bit at the cursor, then applies the Bresenham step:
    - e2=2*err.
    - If e2>-dy: err-=dy, x+=sx.
    - If e2<dx: err+=dx, y+=sy.
  - The cycle that writes (x1,y1) is the last one; the next state is IDLE.
  - The line covers all octants and is inclusive of both endpoints: exactly max(dx,dy)+1 pixels.
  - A degenerate line (x0=x1, y0=y1) writes one pixel.
- Clipping: a cursor with x≥H_RES or y≥V_RES suppresses that write only; stepping continues.
- Reads:
  - `o_pixel_on` = buffer[`i_vcounter`][`i_hcounter`], registered.
  - Forced 0 when the address is outside the buffer.
  - Reads are independent of FSM state.
- Simultaneous read and write to the same pixel: the read returns the old value (read-before-write).
- Reset mid-clear or mid-draw abandons the operation and restarts RST_CLR.

## Timing
- Read latency: 1 cycle, address to `o_pixel_on`.
- A request accepted in IDLE at edge t:
  - `o_waiting` is 0 from t+1.
  - Clear occupies cycles t+1..t+V_RES.
  - SETUP is at t+V_RES+1.
  - DRAW spans N=max(dx,dy)+1 cycles.
  - `o_waiting` returns to 1 at t+V_RES+N+2.
- After reset deasserts, `o_waiting` rises after V_RES cycles.
- Reset values: `o_waiting`=0, `o_pixel_on`=0; FSM in RST_CLR.

## Structure
- Shared package `draw_lines_pkg` holds:
  - the FSM state enum;
  - `COORD_W`=11 and `ERR_W`=13;
  - default H_RES/V_RES.
- One sub-module, `line_frame_buffer`:
  - row-word memory;
  - one row-clear port and one single-bit write port;
  - registered single-bit read port with out-of-range masking.
- Bresenham datapath and FSM live in `draw_lines`.

## Test plan
- Reset, then wait V_RES cycles → `o_waiting`=1 and every read address returns 0.
- Endpoints (0,0)-(3,3), pulse `i_clear_buffer` → after 38 cycles `o_waiting`=1.
  - Reads in rows 0–1, columns 0..5, return 1 only at (0,0) and (1,1).
  - Further reads confirm (2,2) and (3,3) set; all others 0.
- Endpoints (5,2)-(0,4), covering the negative-x shallow octant → exactly 6 pixels set: (5,2),(4,2),(3,3),(2,3),(1,4),(0,4).
- Vertical line (7,0)-(7,31) → 32 pixels in column 7; `o_waiting` rises at t+66.
- Line (30,0)-(40,0) → only (30,0) and (31,0) set; reading address (35,0) returns 0.
- Pulse `i_clear_buffer` during DRAW → ignored, current line completes.
- Assert reset mid-draw → buffer all zeros after V_RES cycles.

Source files
------------

// File: rtl/draw_lines_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : draw_lines_pkg
//  Description : Shared types and constants for the draw_lines rasteriser:
//                FSM state encoding, coordinate/error widths and default
//                frame buffer dimensions.
//  Revision    : 1.0 - initial release
// ============================================================================
package draw_lines_pkg;

    // Coordinate width of endpoints and raster counters.
    localparam int COORD_W = 11;
    // Signed Bresenham arithmetic width; two guard bits above COORD_W keep
    // |dx|, |dy| and 2*err representable.
    localparam int ERR_W = 13;

    localparam int DEFAULT_H_RES = 32;
    localparam int DEFAULT_V_RES = 32;

    typedef enum logic [2:0] {
        RST_CLR = 3'd0,
        IDLE    = 3'd1,
        CLEAR   = 3'd2,
        SETUP   = 3'd3,
        DRAW    = 3'd4
    } state_t;

endpackage : draw_lines_pkg
`default_nettype wire

// File: rtl/line_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : line_frame_buffer
//  Description : 1-bit frame buffer organised as V_RES row words of H_RES
//                bits. One whole-row clear port, one single-bit set port and
//                one registered single-bit read port. Writes and reads
//                outside the buffer are suppressed / return 0.
//  Ports       : i_clk, i_reset       - clock, synchronous active-high reset
//                i_clr_en, i_clr_row  - zero the addressed row
//                i_wr_en, i_wr_x/y    - set the addressed pixel
//                i_rd_x/y, o_rd_data  - pixel read, one cycle latency
//  Revision    : 1.0 - initial release
// ============================================================================
module line_frame_buffer
    import draw_lines_pkg::*;
#(
    parameter int H_RES = DEFAULT_H_RES,
    parameter int V_RES = DEFAULT_V_RES
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clr_en,
    input  logic [COORD_W-1:0] i_clr_row,
    input  logic               i_wr_en,
    input  logic [COORD_W-1:0] i_wr_x,
    input  logic [COORD_W-1:0] i_wr_y,
    input  logic [COORD_W-1:0] i_rd_x,
    input  logic [COORD_W-1:0] i_rd_y,
    output logic               o_rd_data
);

    localparam int c_ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int c_COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam logic [COORD_W-1:0] c_H_LIM = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0] c_V_LIM = COORD_W'(V_RES);

    logic [H_RES-1:0] r_mem [V_RES];
    logic             r_rd_data;

    logic               w_clr_ok;
    logic               w_wr_hit;
    logic               w_rd_hit;
    logic [c_ROW_W-1:0] w_clr_row;
    logic [c_ROW_W-1:0] w_wr_row;
    logic [c_COL_W-1:0] w_wr_col;
    logic [c_ROW_W-1:0] w_rd_row;
    logic [c_COL_W-1:0] w_rd_col;

    // Range checks on the full coordinate so that large addresses never
    // alias onto a real pixel through the truncated index.
    assign w_clr_ok  = i_clr_en && (i_clr_row < c_V_LIM);
    assign w_wr_hit  = i_wr_en && (i_wr_x < c_H_LIM) && (i_wr_y < c_V_LIM);
    assign w_rd_hit  = (i_rd_x < c_H_LIM) && (i_rd_y < c_V_LIM);

    assign w_clr_row = i_clr_row[c_ROW_W-1:0];
    assign w_wr_row  = i_wr_y[c_ROW_W-1:0];
    assign w_wr_col  = i_wr_x[c_COL_W-1:0];
    assign w_rd_row  = i_rd_y[c_ROW_W-1:0];
    assign w_rd_col  = i_rd_x[c_COL_W-1:0];

    // Storage is intentionally not reset; the owner sweeps it with the
    // clear port after reset.
    always_ff @(posedge i_clk) begin
        if (w_clr_ok) begin
            r_mem[w_clr_row] <= '0;
        end
        if (w_wr_hit) begin
            r_mem[w_wr_row][w_wr_col] <= 1'b1;
        end
    end

    // Non-blocking read of r_mem gives read-before-write on a same-pixel
    // collision.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_data <= 1'b0;
        end else begin
            r_rd_data <= w_rd_hit ? r_mem[w_rd_row][w_rd_col] : 1'b0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : line_frame_buffer
`default_nettype wire

// File: rtl/draw_lines.sv
`default_nettype none
// ============================================================================
//  Module      : draw_lines
//  Description : Bresenham line rasteriser into a private 1-bit frame buffer.
//                A clear request latches the endpoints, blanks the buffer one
//                row per cycle, then draws the inclusive line one pixel per
//                cycle. Raster reads are served independently of the FSM.
//  Ports       : i_clk, i_reset          - clock, synchronous active-high reset
//                i_x0/i_y0, i_x1/i_y1    - line endpoints (latched in IDLE)
//                i_clear_buffer          - clear-and-draw request
//                i_hcounter, i_vcounter  - raster read address
//                o_waiting               - idle, ready for a request
//                o_pixel_on              - registered pixel at read address
//  Revision    : 1.0 - initial release
// ============================================================================
module draw_lines
    import draw_lines_pkg::*;
#(
    parameter int H_RES = DEFAULT_H_RES,
    parameter int V_RES = DEFAULT_V_RES
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [COORD_W-1:0] i_x0,
    input  logic [COORD_W-1:0] i_y0,
    input  logic [COORD_W-1:0] i_x1,
    input  logic [COORD_W-1:0] i_y1,
    input  logic               i_clear_buffer,
    input  logic [COORD_W-1:0] i_hcounter,
    input  logic [COORD_W-1:0] i_vcounter,
    output logic               o_waiting,
    output logic               o_pixel_on
);

    localparam logic [COORD_W-1:0] c_ONE      = COORD_W'(1);
    localparam logic [COORD_W-1:0] c_LAST_ROW = COORD_W'(V_RES - 1);

    state_t                    r_state;
    logic [COORD_W-1:0]        r_row;
    logic                      r_waiting;
    logic [COORD_W-1:0]        r_x0, r_y0, r_x1, r_y1;
    logic [COORD_W-1:0]        r_x, r_y;
    logic signed [ERR_W-1:0]   r_dx, r_dy, r_err;
    logic                      r_sx_neg, r_sy_neg;

    logic signed [ERR_W-1:0]   w_dx_raw, w_dy_raw;
    logic signed [ERR_W-1:0]   w_dx_abs, w_dy_abs;
    logic signed [ERR_W-1:0]   w_e2;
    logic signed [ERR_W-1:0]   w_err_next;
    logic                      w_step_x, w_step_y;
    logic                      w_last_pix;
    logic                      w_last_row;
    logic                      w_clr_en;
    logic                      w_wr_en;

    // ---- Setup arithmetic (zero-extended to signed ERR_W) -----------------
    assign w_dx_raw = $signed({2'b00, r_x1}) - $signed({2'b00, r_x0});
    assign w_dy_raw = $signed({2'b00, r_y1}) - $signed({2'b00, r_y0});
    assign w_dx_abs = w_dx_raw[ERR_W-1] ? -w_dx_raw : w_dx_raw;
    assign w_dy_abs = w_dy_raw[ERR_W-1] ? -w_dy_raw : w_dy_raw;

    // ---- Bresenham step ---------------------------------------------------
    assign w_e2     = r_err <<< 1;
    assign w_step_x = (w_e2 > -r_dy);
    assign w_step_y = (w_e2 < r_dx);

    // Both adjustments apply to the same starting err when both fire.
    always_comb begin
        w_err_next = r_err;
        if (w_step_x) begin
            w_err_next = w_err_next - r_dy;
        end
        if (w_step_y) begin
            w_err_next = w_err_next + r_dx;
        end
    end

    assign w_last_pix = (r_x == r_x1) && (r_y == r_y1);
    assign w_last_row = (r_row == c_LAST_ROW);

    assign w_clr_en = (r_state == RST_CLR) || (r_state == CLEAR);
    assign w_wr_en  = (r_state == DRAW) && !i_reset;

    // ---- Control FSM ------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= RST_CLR;
            r_row     <= '0;
            r_waiting <= 1'b0;
            r_x0      <= '0;
            r_y0      <= '0;
            r_x1      <= '0;
            r_y1      <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_dx      <= '0;
            r_dy      <= '0;
            r_err     <= '0;
            r_sx_neg  <= 1'b0;
            r_sy_neg  <= 1'b0;
        end else begin
            case (r_state)
                RST_CLR, CLEAR: begin
                    if (w_last_row) begin
                        r_row <= '0;
                        if (r_state == RST_CLR) begin
                            r_state   <= IDLE;
                            r_waiting <= 1'b1;
                        end else begin
                            r_state <= SETUP;
                        end
                    end else begin
                        r_row <= r_row + c_ONE;
                    end
                end

                IDLE: begin
                    if (i_clear_buffer) begin
                        r_x0      <= i_x0;
                        r_y0      <= i_y0;
                        r_x1      <= i_x1;
                        r_y1      <= i_y1;
                        r_row     <= '0;
                        r_waiting <= 1'b0;
                        r_state   <= CLEAR;
                    end
                end

                SETUP: begin
                    r_dx     <= w_dx_abs;
                    r_dy     <= w_dy_abs;
                    r_err    <= w_dx_abs - w_dy_abs;
                    r_sx_neg <= w_dx_raw[ERR_W-1];
                    r_sy_neg <= w_dy_raw[ERR_W-1];
                    r_x      <= r_x0;
                    r_y      <= r_y0;
                    r_state  <= DRAW;
                end

                DRAW: begin
                    // The pixel at the cursor is written this cycle by the
                    // buffer; the endpoint pixel terminates the line.
                    if (w_last_pix) begin
                        r_state   <= IDLE;
                        r_waiting <= 1'b1;
                    end else begin
                        r_err <= w_err_next;
                        if (w_step_x) begin
                            r_x <= r_sx_neg ? (r_x - c_ONE) : (r_x + c_ONE);
                        end
                        if (w_step_y) begin
                            r_y <= r_sy_neg ? (r_y - c_ONE) : (r_y + c_ONE);
                        end
                    end
                end

                default: begin
                    r_state <= RST_CLR;
                    r_row   <= '0;
                end
            endcase
        end
    end

    assign o_waiting = r_waiting;

    // ---- Frame buffer -----------------------------------------------------
    line_frame_buffer #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_frame_buffer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr_en  (w_clr_en),
        .i_clr_row (r_row),
        .i_wr_en   (w_wr_en),
        .i_wr_x    (r_x),
        .i_wr_y    (r_y),
        .i_rd_x    (i_hcounter),
        .i_rd_y    (i_vcounter),
        .o_rd_data (o_pixel_on)
    );

endmodule : draw_lines
`default_nettype wire

// File: tb/tb_draw_lines.sv
`default_nettype none
// ============================================================================
//  Module      : tb_draw_lines
//  Description : Scoreboard bench for draw_lines. Read requests push the
//                expected pixel into a queue; a monitor pops and compares one
//                cycle later when the registered pixel is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_lines;

    localparam int H_RES = 32;
    localparam int V_RES = 32;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [10:0] i_x0 = '0, i_y0 = '0, i_x1 = '0, i_y1 = '0;
    logic        i_clear_buffer = 1'b0;
    logic [10:0] i_hcounter = '0, i_vcounter = '0;
    logic        o_waiting;
    logic        o_pixel_on;

    always #5 clk = ~clk;

    draw_lines #(.H_RES(H_RES), .V_RES(V_RES)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_x0           (i_x0),
        .i_y0           (i_y0),
        .i_x1           (i_x1),
        .i_y1           (i_y1),
        .i_clear_buffer (i_clear_buffer),
        .i_hcounter     (i_hcounter),
        .i_vcounter     (i_vcounter),
        .o_waiting      (o_waiting),
        .o_pixel_on     (o_pixel_on)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int   x;
        int   y;
        logic exp;
    } rd_t;

    rd_t  sb[$];
    logic rd_req   = 1'b0;
    logic rd_req_d = 1'b0;
    logic exp_img [V_RES][H_RES];

    // ---- Monitor ----------------------------------------------------------
    always @(posedge clk) rd_req_d <= rd_req;

    always @(negedge clk) begin
        rd_t e;
        if (rd_req_d) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: pixel presented with no expectation");
            end else begin
                e = sb.pop_front();
                if (o_pixel_on !== e.exp) begin
                    n_fail++;
                    $display("FAIL pixel(%0d,%0d): got %b expected %b",
                             e.x, e.y, o_pixel_on, e.exp);
                end
            end
        end
    end

    // ---- Helpers ----------------------------------------------------------
    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int y = 0; y < V_RES; y++)
            for (int x = 0; x < H_RES; x++)
                exp_img[y][x] = 1'b0;
    endtask

    task automatic read_px(input int x, input int y, input logic exp);
        rd_t e;
        @(negedge clk);
        i_hcounter = 11'(x);
        i_vcounter = 11'(y);
        rd_req     = 1'b1;
        e.x = x; e.y = y; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic read_drain();
        @(negedge clk);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        check_int("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic scan_all();
        for (int y = 0; y < V_RES; y++)
            for (int x = 0; x < H_RES; x++)
                read_px(x, y, exp_img[y][x]);
        read_drain();
    endtask

    // Holds reset, checks reset outputs, releases and times o_waiting.
    task automatic reset_and_wait(input string name);
        int p;
        @(negedge clk);
        i_reset    = 1'b1;
        i_hcounter = 11'd1;
        i_vcounter = 11'd1;
        repeat (3) @(negedge clk);
        check_int({name, "_waiting_in_reset"}, int'(o_waiting), 0);
        check_int({name, "_pixel_in_reset"}, int'(o_pixel_on), 0);
        i_reset = 1'b0;
        p = 0;
        while (p < 200) begin
            @(negedge clk);
            p++;
            if (o_waiting) break;
        end
        check_int({name, "_waiting_latency"}, p, V_RES);
    endtask

    // Issues one request; pulse_at > 0 re-pulses i_clear_buffer (with other
    // endpoints) at that cycle after acceptance.
    task automatic do_line(input int x0, input int y0, input int x1, input int y1,
                           input int n_pix, input int pulse_at, input string name);
        int p;
        @(negedge clk);
        check_int({name, "_ready"}, int'(o_waiting), 1);
        i_x0 = 11'(x0); i_y0 = 11'(y0); i_x1 = 11'(x1); i_y1 = 11'(y1);
        i_clear_buffer = 1'b1;
        @(negedge clk);
        i_clear_buffer = 1'b0;
        // Endpoints must have been latched; change them underneath.
        i_x0 = 11'd9; i_y0 = 11'd17; i_x1 = 11'd3; i_y1 = 11'd25;
        p = 1;
        check_int({name, "_busy"}, int'(o_waiting), 0);
        while (p < 400) begin
            @(negedge clk);
            p++;
            if (p == pulse_at) begin
                i_x0 = 11'd0; i_y0 = 11'd0; i_x1 = 11'd1; i_y1 = 11'd1;
                i_clear_buffer = 1'b1;
            end else begin
                i_clear_buffer = 1'b0;
            end
            if (o_waiting) break;
        end
        i_clear_buffer = 1'b0;
        check_int({name, "_done_cycle"}, p, V_RES + n_pix + 2);
    endtask

    // ---- Stimulus ---------------------------------------------------------
    initial begin
        // Reset: buffer swept, everything reads 0
        reset_and_wait("reset");
        model_clear();
        scan_all();

        // Diagonal (0,0)-(3,3): done at cycle 38
        do_line(0, 0, 3, 3, 4, 0, "diag");
        model_clear();
        exp_img[0][0] = 1; exp_img[1][1] = 1; exp_img[2][2] = 1; exp_img[3][3] = 1;
        scan_all();

        // Negative-x shallow octant (5,2)-(0,4)
        do_line(5, 2, 0, 4, 6, 0, "neg_x");
        model_clear();
        exp_img[2][5] = 1; exp_img[2][4] = 1; exp_img[3][3] = 1;
        exp_img[3][2] = 1; exp_img[4][1] = 1; exp_img[4][0] = 1;
        scan_all();

        // Vertical full-height line: done at cycle 66
        do_line(7, 0, 7, 31, 32, 0, "vert");
        model_clear();
        for (int y = 0; y < V_RES; y++) exp_img[y][7] = 1;
        scan_all();

        // Clipped line (30,0)-(40,0): 11 steps, 2 visible pixels
        do_line(30, 0, 40, 0, 11, 0, "clip");
        model_clear();
        exp_img[0][30] = 1; exp_img[0][31] = 1;
        scan_all();
        read_px(35, 0, 1'b0);
        read_px(62, 0, 1'b0);    // would alias column 30 without masking
        read_px(30, 32, 1'b0);   // would alias row 0 without masking
        read_px(2047, 2047, 1'b0);
        read_drain();

        // Request during DRAW is ignored and not queued
        do_line(0, 10, 20, 10, 21, V_RES + 5, "ignore_req");
        repeat (4) @(negedge clk);
        check_int("ignore_req_no_queue", int'(o_waiting), 1);
        model_clear();
        for (int x = 0; x <= 20; x++) exp_img[10][x] = 1;
        scan_all();

        // Reset mid-draw abandons the line and re-sweeps the buffer
        @(negedge clk);
        i_x0 = 11'd0; i_y0 = 11'd0; i_x1 = 11'd31; i_y1 = 11'd31;
        i_clear_buffer = 1'b1;
        @(negedge clk);
        i_clear_buffer = 1'b0;
        repeat (V_RES + 10) @(negedge clk);
        reset_and_wait("mid_draw_reset");
        model_clear();
        scan_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_draw_lines
`default_nettype wire
